alu_cmd_dispatcher: RTL and testbench
=====================================

# alu_cmd_dispatcher

Hardware initiator for the IEEE-754 ALU's start/valid_out handshake. It buffers operation commands from an upstream master in a small FIFO and issues them to the ALU one at a time. For each command it captures the ALU result and flags into a response register with a valid/ready interface, and it keeps sticky exception flags. It sits between the control datapath and the `alu` instance, and it replaces the sequencing that the bench currently does by hand.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 64: maximum cycles in ISSUE waiting for `alu_valid_out`; at least 2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_a` in 32: operand A; half precision uses bits [15:0].
- `cmd_b` in 32: operand B.
- `cmd_op` in 3: op code (000 add, 001 sub, 010 mul, 011 div).
- `cmd_mode` in 1: 1 = single precision, 0 = half precision.
- `cmd_round` in 1: rounding mode, passed through.
- `alu_op_a` out 32, `alu_op_b` out 32, `alu_op_code` out 3, `alu_mode_fp` out 1, `alu_round_mode` out 1: ALU operand and control drive.
- `alu_start` out 1: ALU start.
- `alu_result` in 32: ALU result.
- `alu_flags` in 5: {invalid, div_by_zero, overflow, underflow, inexact}.
- `alu_valid_out` in 1: ALU result valid.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_result` out 32: captured result.
- `rsp_flags` out 5: captured flags.
- `rsp_timeout` out 1: the response came from a timeout abort.
- `sticky_flags` out 5: OR of all captured `rsp_flags` since reset or the last clear.
- `clr_sticky` in 1: synchronous clear of `sticky_flags`.
- `busy` out 1: FSM is not in IDLE, or the FIFO is non-empty.

## Operation
- **FIFO.**
  - Each entry is 69 bits: a, b, op, mode, round.
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. It does not look at a same-cycle pop, so a full FIFO refuses a push even while it pops.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Order is strictly FIFO.
- **FSM states:** IDLE, ISSUE, DRAIN.
- **IDLE**
  - When the FIFO is non-empty and `rsp_valid == 0`: pop the head, load it into the `alu_*` operand registers, set `alu_start = 1`, clear the timeout counter, and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `alu_start` and the operands are held stable.
  - If `alu_valid_out == 1` is sampled:
    - `rsp_result <= alu_result`, `rsp_flags <= alu_flags`, `rsp_timeout <= 0`, `rsp_valid <= 1`.
    - `sticky_flags |= alu_flags`.
    - `alu_start <= 0`, go to DRAIN.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES - 1`:
    - `rsp_result <= 0`, `rsp_flags <= 0`, `rsp_timeout <= 1`, `rsp_valid <= 1`.
    - `alu_start <= 0`, go to DRAIN.
- **DRAIN**
  - `alu_start` is 0.
  - When `alu_valid_out == 0` is sampled, go to IDLE.
  - Operands keep their last values until the next issue.
- **Response register.**
  - `rsp_valid` clears on `rsp_valid && rsp_ready`.
  - Capture happens only when `rsp_valid` is 0, which the IDLE gating guarantees, so no response is ever overwritten.
- **Sticky flags.**
  - If `clr_sticky` and a capture occur in the same cycle, the new flags win: the result is `sticky_flags = alu_flags`.
- **Reset** (asynchronous, at any point including mid-ISSUE):
  - FSM to IDLE, FIFO emptied, and every output 0 (`alu_start`, operands, `rsp_*`, `sticky_flags`).
  - `cmd_ready` is 1 after reset deassertion.
  - Any in-flight command is lost.

## Timing
- **Cycle numbering:** cycle 0 is the edge where the command is accepted into an empty FIFO.
  - Cycle 1: FIFO non-empty and FSM in IDLE, so the pop happens.
  - Cycle 2: `alu_start` is high.
- **Capture:** if `alu_valid_out` is first high in cycle k, then at cycle k+1 `alu_start` = 0, `rsp_valid` = 1 and the response is visible.
- **Next issue:** in DRAIN, once `alu_valid_out` is sampled low, the FSM is in IDLE the following cycle. The next issue occurs at the earliest one cycle after both `rsp_valid` is 0 and the FIFO is non-empty.
- **Timeout:** `alu_start` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_timeout` = 1.
- **Throughput:** at most one outstanding ALU operation.
- **Response handshake:** `rsp_ready` may be held high permanently.
- **Back-pressure:** `rsp_ready` low stalls issue but not FIFO fill.

## Test plan
- **SP add:** `3F800000 + 3F800000`, op 000, mode 1, with the real `alu` → `rsp_result = 40000000`, `rsp_flags = 00000`. `alu_start` falls exactly one cycle after `alu_valid_out` first rises.
- **HP divide:** `00004400 / 00004000`, op 011, mode 0 → `rsp_result[15:0] = 4000`, `rsp_timeout = 0`.
- **Back-pressure and ordering:** hold `rsp_ready = 0` and push 6 commands (A0..A5, DEPTH = 4).
  - A0 issues, and its response is held.
  - A1..A4 fill the FIFO; `cmd_ready = 0` while A5 is offered.
  - After `rsp_ready` rises, responses arrive in order A0..A5 with no duplicates.
- **Div by zero:** `3F800000 / 00000000`, op 011, mode 1 → `rsp_flags[3] = 1` and `sticky_flags[3] = 1`.
  - `sticky_flags[3]` stays 1 across a following clean add.
  - It is 0 the cycle after `clr_sticky`.
- **Timeout:** ALU stub with `alu_valid_out` stuck at 0, `TIMEOUT_CYCLES = 16` → `alu_start` is high for 16 cycles, then `rsp_timeout = 1`, `rsp_result = 0`, and the FSM returns to IDLE.
- **Reset mid-ISSUE:** assert `rst` asynchronously mid-cycle while `alu_start` = 1 and 2 commands are queued.
  - `alu_start`, `rsp_valid` and `busy` go to 0 immediately.
  - After release, `cmd_ready = 1` and a new `3F800000 + 3F800000` returns `40000000`.

Source files
------------

// File: rtl/alu_cmd_dispatcher_if.sv
// Command, ALU drive and response signals of the ALU command dispatcher.
// The dispatcher is the initiator of the ALU handshake and uses the master
// modport; upstream, the ALU and the response consumer use the slave modport.
interface alu_cmd_dispatcher_if;
  // upstream command
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic        cmd_mode;
  logic        cmd_round;
  // ALU drive and return
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [2:0]  alu_op_code;
  logic        alu_mode_fp;
  logic        alu_round_mode;
  logic        alu_start;
  logic [31:0] alu_result;
  logic [4:0]  alu_flags;
  logic        alu_valid_out;
  // response and status
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_timeout;
  logic [4:0]  sticky_flags;
  logic        clr_sticky;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_mode, cmd_round,
    output cmd_ready,
    output alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode, alu_start,
    input  alu_result, alu_flags, alu_valid_out,
    output rsp_valid, rsp_result, rsp_flags, rsp_timeout, sticky_flags, busy,
    input  rsp_ready, clr_sticky
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_mode, cmd_round,
    input  cmd_ready,
    input  alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode, alu_start,
    output alu_result, alu_flags, alu_valid_out,
    input  rsp_valid, rsp_result, rsp_flags, rsp_timeout, sticky_flags, busy,
    output rsp_ready, clr_sticky
  );
endinterface

// File: rtl/alu_cmd_dispatcher.sv
// ALU command dispatcher: buffers commands in a FIFO, issues them one at a
// time over the ALU start/valid_out handshake, captures each result into a
// valid/ready response register and accumulates sticky exception flags.
module alu_cmd_dispatcher #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,
  alu_cmd_dispatcher_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic        rnd;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            in_cmd;
  cmd_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   tmo_cnt;
  logic            full;
  logic            empty;
  logic            push;

  // FIFO status; a full FIFO refuses a push even in a cycle that pops
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign in_cmd = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op,
                    mode: bus.cmd_mode, rnd: bus.cmd_round};

  assign bus.cmd_ready = !full;
  assign bus.busy      = (state != IDLE) || !empty;

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_cmd;
  end

  // Issue sequencing, response capture, sticky flags and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      tmo_cnt            <= '0;
      bus.alu_op_a       <= '0;
      bus.alu_op_b       <= '0;
      bus.alu_op_code    <= '0;
      bus.alu_mode_fp    <= 1'b0;
      bus.alu_round_mode <= 1'b0;
      bus.alu_start      <= 1'b0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_result     <= '0;
      bus.rsp_flags      <= '0;
      bus.rsp_timeout    <= 1'b0;
      bus.sticky_flags   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (bus.rsp_valid && bus.rsp_ready) bus.rsp_valid <= 1'b0;
      if (bus.clr_sticky) bus.sticky_flags <= '0;

      case (state)
        IDLE: begin
          // rsp_valid gating guarantees a capture never overwrites a response
          if (!empty && !bus.rsp_valid) begin
            rd_ptr             <= rd_ptr + PW'(1);
            bus.alu_op_a       <= head.a;
            bus.alu_op_b       <= head.b;
            bus.alu_op_code    <= head.op;
            bus.alu_mode_fp    <= head.mode;
            bus.alu_round_mode <= head.rnd;
            bus.alu_start      <= 1'b1;
            tmo_cnt            <= '0;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.alu_valid_out) begin
            bus.rsp_result   <= bus.alu_result;
            bus.rsp_flags    <= bus.alu_flags;
            bus.rsp_timeout  <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            // a same-cycle clear loses to the newly captured flags
            bus.sticky_flags <= bus.clr_sticky ? bus.alu_flags
                                               : (bus.sticky_flags | bus.alu_flags);
            bus.alu_start    <= 1'b0;
            state            <= DRAIN;
          end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_result   <= '0;
            bus.rsp_flags    <= '0;
            bus.rsp_timeout  <= 1'b1;
            bus.rsp_valid    <= 1'b1;
            bus.alu_start    <= 1'b0;
            state            <= DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        DRAIN: begin
          // wait for the ALU to drop valid_out before the next issue
          if (!bus.alu_valid_out) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Self-checking bench for alu_cmd_dispatcher: behavioural ALU stub with random
// latency, scoreboard of expected responses in command order, directed cases.
module tb_alu_cmd_dispatcher;

  localparam int unsigned TMO = 16;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        timeout;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_cmd_dispatcher_if bus();

  alu_cmd_dispatcher #(.DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  rsp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rsp    = 0;
  logic [4:0]  ref_sticky = '0;
  logic        stuck = 1'b0;
  int          rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random
  int          lat = 0;
  int          scnt = 0;
  logic        valid_q = 1'b0;
  logic        cap_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural ALU: known IEEE results for the directed vectors, an
  // asymmetric operand hash otherwise. Returns {flags, result}.
  function automatic logic [36:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic mode,
                                            input logic rnd);
    logic [31:0] r;
    logic [4:0]  f;
    if (op == 3'd0 && mode && a == 32'h3F800000 && b == 32'h3F800000)
      return {5'b00000, 32'h40000000};
    if (op == 3'd3 && !mode && a == 32'h00004400 && b == 32'h00004000)
      return {5'b00000, 32'h00004000};
    if (op == 3'd3 && mode && a == 32'h3F800000 && b == 32'h00000000)
      return {5'b01000, 32'h7F800000};
    r = (a * 32'd3) ^ {b[7:0], b[31:8]} ^ {28'h0, op, rnd};
    if (!mode) r[31:16] = 16'h0;
    f = r[9:5] ^ r[27:23];
    return {f, r};
  endfunction

  // ALU stub: result valid after a random latency while start is held
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_valid_out <= 1'b0;
      bus.alu_result    <= '0;
      bus.alu_flags     <= '0;
      scnt              <= 0;
    end else if (!bus.alu_start) begin
      bus.alu_valid_out <= 1'b0;
      scnt              <= 0;
      lat               <= int'($urandom_range(0, 3));
    end else if (!stuck && !bus.alu_valid_out) begin
      if (scnt >= lat) begin
        {bus.alu_flags, bus.alu_result} <= alu_model(bus.alu_op_a, bus.alu_op_b,
                                                     bus.alu_op_code, bus.alu_mode_fp,
                                                     bus.alu_round_mode);
        bus.alu_valid_out <= 1'b1;
      end else begin
        scnt <= scnt + 1;
      end
    end
  end

  // Response consumer handshake driver
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: capture timing and in-order response scoreboard
  always @(posedge clk) begin
    if (rst) begin
      cap_pending <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      if (cap_pending) begin
        check("cap_start_low", 32'(bus.alu_start), 32'd0);
        check("cap_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      end
      cap_pending <= bus.alu_valid_out && !valid_q && bus.alu_start;
      valid_q     <= bus.alu_valid_out;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_result", bus.rsp_result, e.result);
          check("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
          check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
          ref_sticky = ref_sticky | e.flags;
          n_rsp++;
        end
      end
    end
  end

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic mode, input logic rnd);
    int   waited;
    rsp_t e;
    logic [36:0] m;
    waited = 0;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
    bus.cmd_mode = mode; bus.cmd_round = rnd; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    check("push_accept", 32'(bus.cmd_ready), 32'd1);
    if (bus.cmd_ready) begin
      m = alu_model(a, b, op, mode, rnd);
      if (stuck) begin
        e.result = '0; e.flags = '0; e.timeout = 1'b1;
      end else begin
        e.result = m[31:0]; e.flags = m[36:32]; e.timeout = 1'b0;
      end
      @(posedge clk);
      exp_q.push_back(e);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      done = (exp_q.size() == 0) && !bus.busy && !bus.rsp_valid;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nsent;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.cmd_mode = 1'b0; bus.cmd_round = 1'b0; bus.clr_sticky = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_start", 32'(bus.alu_start), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sticky", 32'(bus.sticky_flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // SP add and HP divide
    push_cmd(32'h3F800000, 32'h3F800000, 3'd0, 1'b1, 1'b0);
    wait_idle("idle_sp_add");
    push_cmd(32'h00004400, 32'h00004000, 3'd3, 1'b0, 1'b0);
    wait_idle("idle_hp_div");

    // back-pressure and ordering
    rdy_mode = 0;
    @(posedge clk); #1;
    nsent = n_rsp;
    for (int i = 0; i < 5; i++)
      push_cmd(32'hA000_0000 + 32'(i * 7919), 32'h1234_0000 + 32'(i), 3'(i % 4), 1'b1, 1'(i));
    bus.cmd_a = 32'hA5A5_0005; bus.cmd_b = 32'h0000_5555; bus.cmd_op = 3'd2;
    bus.cmd_mode = 1'b1; bus.cmd_round = 1'b1; bus.cmd_valid = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("bp_rsp_held", 32'(bus.rsp_valid), 32'd1);
    check("bp_no_rsp", 32'(n_rsp - nsent), 32'd0);
    rdy_mode = 1;
    push_cmd(32'hA5A5_0005, 32'h0000_5555, 3'd2, 1'b1, 1'b1);
    wait_idle("idle_bp");
    check("bp_rsp_count", 32'(n_rsp - nsent), 32'd6);

    // sticky flags: div-by-zero, clean add, clear
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1;
    bus.clr_sticky = 1'b0;
    ref_sticky = '0;
    push_cmd(32'h3F800000, 32'h00000000, 3'd3, 1'b1, 1'b0);
    wait_idle("idle_dbz");
    check("dbz_sticky3", 32'(bus.sticky_flags[3]), 32'd1);
    push_cmd(32'h3F800000, 32'h3F800000, 3'd0, 1'b1, 1'b0);
    wait_idle("idle_clean");
    check("sticky_hold", 32'(bus.sticky_flags), 32'(ref_sticky));
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1;
    bus.clr_sticky = 1'b0;
    ref_sticky = '0;
    check("sticky_clr", 32'(bus.sticky_flags), 32'd0);

    // timeout with a silent ALU
    stuck = 1'b1;
    push_cmd(32'h1111_1111, 32'h2222_2222, 3'd0, 1'b1, 1'b0);
    cnt = 0;
    while (!bus.alu_start && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("tmo_start_seen", 32'(bus.alu_start), 32'd1);
    cnt = 0;
    while (bus.alu_start && cnt < 200) begin cnt++; @(posedge clk); #1; end
    check("tmo_start_cycles", 32'(cnt), 32'(TMO));
    wait_idle("idle_tmo");
    stuck = 1'b0;

    // asynchronous reset while issuing with two commands queued
    stuck = 1'b1;
    push_cmd(32'h0101_0101, 32'h0202_0202, 3'd1, 1'b1, 1'b0);
    push_cmd(32'h0303_0303, 32'h0404_0404, 3'd2, 1'b1, 1'b0);
    push_cmd(32'h0505_0505, 32'h0606_0606, 3'd3, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_start_high", 32'(bus.alu_start), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_alu_start", 32'(bus.alu_start), 32'd0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    stuck = 1'b0;
    ref_sticky = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    push_cmd(32'h3F800000, 32'h3F800000, 3'd0, 1'b1, 1'b0);
    wait_idle("idle_after_rst");

    // random traffic with random back-pressure
    rdy_mode = 2;
    nsent = n_rsp;
    for (int i = 0; i < 40; i++) begin
      push_cmd($urandom, $urandom, 3'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    wait_idle("idle_random");
    check("rand_rsp_count", 32'(n_rsp - nsent), 32'd40);
    check("rand_sticky", 32'(bus.sticky_flags), 32'(ref_sticky));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
